// File: rtl/note_envelope.sv
// ADSR envelope generator for one note voice.
// Scales the sine half-wave magnitudes by the envelope level.
module note_envelope #(
  parameter int N            = 8,
  parameter int RATE_DIV     = 16,
  parameter int ATTACK_STEP  = 8,
  parameter int DECAY_STEP   = 1,
  parameter int SUSTAIN_LVL  = 192,
  parameter int RELEASE_STEP = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fs_tick,
  input  logic         note_on,
  input  logic         note_off,
  input  logic [N-1:0] pos_in,
  input  logic [N-1:0] neg_in,
  output logic [N-1:0] pos_out,
  output logic [N-1:0] neg_out,
  output logic [N-1:0] env_level,
  output logic         active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATE_DIV - 1);
  localparam logic [N:0] MAX_LVL = {1'b0, {N{1'b1}}};
  localparam logic [N:0] A_STEP  = (N+1)'(ATTACK_STEP);
  localparam logic [N:0] D_STEP  = (N+1)'(DECAY_STEP);
  localparam logic [N:0] R_STEP  = (N+1)'(RELEASE_STEP);
  localparam logic [N:0] SUS_LVL = (N+1)'(SUSTAIN_LVL);

  state_t        state_q, state_d;
  logic [N-1:0]  level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  pos_q, pos_d;
  logic [N-1:0]  neg_q, neg_d;

  logic          upd;
  logic [N:0]    lvl_ext;
  logic [N:0]    a_sum;
  logic [N:0]    d_diff;
  logic [N:0]    r_diff;
  logic [2*N-1:0] pos_prod;
  logic [2*N-1:0] neg_prod;

  // State, level, rate counter and sample registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  // Next state, envelope level and rate counter; commands beat updates
  always_comb begin
    upd     = fs_tick && (cnt_q == CNT_LAST);
    lvl_ext = {1'b0, level_q};
    a_sum   = lvl_ext + A_STEP;
    d_diff  = lvl_ext - D_STEP;
    r_diff  = lvl_ext - R_STEP;
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (fs_tick) begin
      cnt_d = upd ? '0 : cnt_q + 1'b1;
    end
    if (note_on) begin
      state_d = S_ATTACK;
      cnt_d   = '0;
    end else if (note_off && (state_q == S_ATTACK ||
                              state_q == S_DECAY ||
                              state_q == S_SUSTAIN)) begin
      state_d = S_RELEASE;
      cnt_d   = '0;
    end else if (upd) begin
      case (state_q)
        S_ATTACK: begin
          if (a_sum >= MAX_LVL) begin
            level_d = MAX_LVL[N-1:0];
            state_d = S_DECAY;
          end else begin
            level_d = a_sum[N-1:0];
          end
        end
        S_DECAY: begin
          if (lvl_ext <= SUS_LVL + D_STEP) begin
            level_d = SUS_LVL[N-1:0];
            state_d = S_SUSTAIN;
          end else begin
            level_d = d_diff[N-1:0];
          end
        end
        S_RELEASE: begin
          if (lvl_ext <= R_STEP) begin
            level_d = '0;
            state_d = S_IDLE;
          end else begin
            level_d = r_diff[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Sample scaling: full-width product, keep the top N bits
  always_comb begin
    pos_prod = (2*N)'(pos_in) * (2*N)'(level_q);
    neg_prod = (2*N)'(neg_in) * (2*N)'(level_q);
    pos_d    = fs_tick ? pos_prod[2*N-1:N] : pos_q;
    neg_d    = fs_tick ? neg_prod[2*N-1:N] : neg_q;
  end

  // Outputs straight from the registers
  always_comb begin
    active    = (state_q != S_IDLE);
    env_level = level_q;
    pos_out   = pos_q;
    neg_out   = neg_q;
  end

endmodule

// File: tb/tb_note_envelope.sv
// Scoreboard bench for note_envelope.
// Directed envelope walk followed by random commands and samples.
module tb_note_envelope;

  localparam int N    = 8;
  localparam int RD   = 16;
  localparam int ASTP = 8;
  localparam int DSTP = 1;
  localparam int SUS  = 192;
  localparam int RSTP = 2;
  localparam int MAXL = 255;

  localparam int P_IDLE = 0;
  localparam int P_ATK  = 1;
  localparam int P_DEC  = 2;
  localparam int P_SUS  = 3;
  localparam int P_REL  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         fs_tick = 1'b0;
  logic         note_on = 1'b0;
  logic         note_off = 1'b0;
  logic [N-1:0] pos_in = '0;
  logic [N-1:0] neg_in = '0;
  logic [N-1:0] pos_out;
  logic [N-1:0] neg_out;
  logic [N-1:0] env_level;
  logic         active;

  note_envelope #(
    .N(N), .RATE_DIV(RD), .ATTACK_STEP(ASTP),
    .DECAY_STEP(DSTP), .SUSTAIN_LVL(SUS),
    .RELEASE_STEP(RSTP)
  ) dut (
    .clk(clk), .reset(reset), .fs_tick(fs_tick),
    .note_on(note_on), .note_off(note_off),
    .pos_in(pos_in), .neg_in(neg_in),
    .pos_out(pos_out), .neg_out(neg_out),
    .env_level(env_level), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int env;
    int act;
    int pos;
    int neg;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  int m_ph  = P_IDLE;
  int m_lvl = 0;
  int m_cnt = 0;
  int m_pos = 0;
  int m_neg = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Reference model: one clock of behaviour from the envelope rules
  task automatic model_step(input bit rst, input bit tk,
                            input bit on, input bit off,
                            input int pi, input int ni);
    bit due;
    if (rst) begin
      m_ph = P_IDLE; m_lvl = 0; m_cnt = 0;
      m_pos = 0; m_neg = 0;
      return;
    end
    if (tk) begin
      m_pos = (pi * m_lvl) / 256;
      m_neg = (ni * m_lvl) / 256;
    end
    due = tk && (m_cnt == RD - 1);
    if (tk) m_cnt = due ? 0 : m_cnt + 1;
    if (on) begin
      m_ph = P_ATK; m_cnt = 0;
    end else if (off && m_ph != P_IDLE && m_ph != P_REL) begin
      m_ph = P_REL; m_cnt = 0;
    end else if (due) begin
      if (m_ph == P_ATK) begin
        m_lvl = imin(m_lvl + ASTP, MAXL);
        if (m_lvl == MAXL) m_ph = P_DEC;
      end else if (m_ph == P_DEC) begin
        m_lvl = imax(m_lvl - DSTP, SUS);
        if (m_lvl == SUS) m_ph = P_SUS;
      end else if (m_ph == P_REL) begin
        m_lvl = imax(m_lvl - RSTP, 0);
        if (m_lvl == 0) m_ph = P_IDLE;
      end
    end
  endtask

  // Drive one clock of stimulus and queue the expected response
  task automatic cyc(input bit rst, input bit tk,
                     input bit on, input bit off,
                     input int pi, input int ni);
    exp_t e;
    reset    = rst;
    fs_tick  = tk;
    note_on  = on;
    note_off = off;
    pos_in   = pi[N-1:0];
    neg_in   = ni[N-1:0];
    model_step(rst, tk, on, off, pi, ni);
    e.env = m_lvl;
    e.act = (m_ph != P_IDLE) ? 1 : 0;
    e.pos = m_pos;
    e.neg = m_neg;
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n, input int pi, input int ni);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, pi, ni);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: compare DUT against the oldest queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (int'(env_level) != e.env || int'(active) != e.act ||
          int'(pos_out) != e.pos || int'(neg_out) != e.neg) begin
        errors++;
        $display("FAIL sb t=%0t got env=%0d act=%0d pos=%0d neg=%0d expected env=%0d act=%0d pos=%0d neg=%0d",
                 $time, env_level, active, pos_out, neg_out,
                 e.env, e.act, e.pos, e.neg);
      end
    end
  end

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 200, 200);
    chk("reset_env", int'(env_level), 0);
    chk("reset_active", int'(active), 0);

    ticks(1000, 200, 200);
    chk("idle_pos", int'(pos_out), 0);
    chk("idle_neg", int'(neg_out), 0);
    chk("idle_env", int'(env_level), 0);
    chk("idle_active", int'(active), 0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    chk("on_active", int'(active), 1);
    ticks(511, 0, 0);
    chk("attack_pre_top", int'(env_level), 248);
    ticks(1, 0, 0);
    chk("attack_top", int'(env_level), 255);
    ticks(1, 255, 0);
    chk("full_scale_pos", int'(pos_out), 254);
    ticks(1007, 37, 90);
    chk("decay_sustain", int'(env_level), 192);
    ticks(100, 0, 0);
    chk("sustain_hold", int'(env_level), 192);
    ticks(1, 200, 0);
    chk("sustain_pos", int'(pos_out), 150);
    chk("sustain_neg", int'(neg_out), 0);

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    ticks(736, 0, 0);
    chk("release_100", int'(env_level), 100);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    chk("retrig_env", int'(env_level), 100);
    chk("retrig_active", int'(active), 1);
    ticks(16, 0, 0);
    chk("retrig_step", int'(env_level), 108);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    ticks(128, 0, 0);
    chk("attack_64", int'(env_level), 64);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 255, 255);
    chk("midreset_env", int'(env_level), 0);
    chk("midreset_active", int'(active), 0);
    chk("midreset_pos", int'(pos_out), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    ticks(16, 0, 0);
    chk("restart_8", int'(env_level), 8);

    ticks(496 + 1008, 0, 0);
    chk("second_sustain", int'(env_level), 192);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    ticks(1535, 0, 0);
    chk("release_last", int'(env_level), 2);
    chk("release_last_act", int'(active), 1);
    ticks(1, 0, 0);
    chk("release_zero", int'(env_level), 0);
    chk("release_idle", int'(active), 0);

    for (int i = 0; i < 5000; i++) begin
      cyc($urandom_range(0, 799) == 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 399) == 0,
          $urandom_range(0, 249) == 0,
          int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)));
    end

    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
